// File: rtl/arb_round_robin_4.sv
// Four-way round-robin arbiter with a bounded hold time and a one-cycle
// bus-turnaround gap between consecutive grants.
module arb_round_robin_4 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  input  logic [3:0] done_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gntId_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gntId_q, gntId_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [7:0] holdCnt_q, holdCnt_d;
  logic [1:0] last_q, last_d;

  logic [1:0] winner;
  logic [1:0] candidate;
  logic       ownerRelease;
  logic       holdExpired;

  // Walk offsets from far to near so the nearest requester after last_q wins.
  always_comb begin
    winner    = last_q;
    candidate = last_q;
    for (int k = 4; k >= 1; k--) begin
      candidate = last_q + 2'(k);
      if (req_i[candidate]) begin
        winner = candidate;
      end
    end
  end

  assign ownerRelease = done_i[gntId_q] | ~req_i[gntId_q];
  assign holdExpired  = (holdCnt_q == MaxHold);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gntId_d   = gntId_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    holdCnt_d = holdCnt_q;
    last_d    = last_q;

    unique case (state_q)
      IDLE, GAP: begin
        gnt_d  = 4'b0000;
        busy_d = 1'b0;
        if (|req_i) begin
          state_d   = GRANT;
          gnt_d     = 4'b0001 << winner;
          gntId_d   = winner;
          busy_d    = 1'b1;
          last_d    = winner;
          holdCnt_d = 8'd1;
        end else begin
          state_d   = IDLE;
          holdCnt_d = 8'd0;
        end
      end

      GRANT: begin
        // A release in the expiry cycle wins, so no timeout is flagged then.
        if (ownerRelease || holdExpired) begin
          state_d   = GAP;
          gnt_d     = 4'b0000;
          busy_d    = 1'b0;
          timeout_d = ~ownerRelease;
          holdCnt_d = 8'd0;
        end else begin
          holdCnt_d = holdCnt_q + 8'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        gnt_d     = 4'b0000;
        busy_d    = 1'b0;
        holdCnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gntId_q   <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      holdCnt_q <= 8'd0;
      last_q    <= 2'd3;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gntId_q   <= gntId_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      holdCnt_q <= holdCnt_d;
      last_q    <= last_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gntId_o   = gntId_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_arb_round_robin_4.sv
// Directed and random checks for arb_round_robin_4 against a cycle-level
// reference model feeding an expected-output queue.
module tb_arb_round_robin_4;

  localparam int MH    = 15;
  localparam int Bound = 3 * (MH + 1) + 2;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } obs_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] reqDrv  = 4'b0000;
  logic [3:0] doneDrv = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gntId;
  logic       busy;
  logic       timeout;

  int checkCount = 0;
  int passCount  = 0;

  obs_t expQ[$];

  // Reference model state: phase 0 idle, 1 owned, 2 turnaround gap.
  int   mPhase = 0;
  int   mLast  = 3;
  int   mOwner = 0;
  int   mHeld  = 0;
  logic mTo    = 1'b0;

  int waitCnt[4];

  arb_round_robin_4 #(.MAX_HOLD(MH)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (reqDrv),
    .done_i    (doneDrv),
    .gnt_o     (gnt),
    .gntId_o   (gntId),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    mPhase = 0;
    mLast  = 3;
    mOwner = 0;
    mHeld  = 0;
    mTo    = 1'b0;
  endtask

  task automatic modelStep();
    obs_t e;
    bit   rel;
    bit   found;
    if (!rst_n) begin
      modelReset();
    end else begin
      mTo = 1'b0;
      if (mPhase == 1) begin
        rel = doneDrv[mOwner] || !reqDrv[mOwner];
        if (rel || mHeld == MH) begin
          mTo    = !rel;
          mPhase = 2;
          mHeld  = 0;
        end else begin
          mHeld++;
        end
      end else begin
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && reqDrv[(mLast + k) % 4]) begin
            mOwner = (mLast + k) % 4;
            found  = 1;
          end
        end
        if (found) begin
          mPhase = 1;
          mLast  = mOwner;
          mHeld  = 1;
        end else begin
          mPhase = 0;
        end
      end
    end
    e.gnt  = (mPhase == 1) ? (4'b0001 << mOwner) : 4'b0000;
    e.id   = 2'(mOwner);
    e.busy = (mPhase == 1);
    e.to   = mTo;
    expQ.push_back(e);
  endtask

  // Inputs r/d are present for the current cycle; outputs checked #1 after the edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
    obs_t e;
    reqDrv  = r;
    doneDrv = d;
    @(posedge clk);
    modelStep();
    #1;
    if (expQ.size() == 0) begin
      checkCount++;
      $error("FAIL sb_underflow: observed=empty expected=entry");
    end else begin
      e = expQ.pop_front();
      checkOutput("sb", {gnt, gntId, busy, timeout}, e);
    end
  endtask

  initial begin
    logic [3:0] exp;
    logic [3:0] r;
    foreach (waitCnt[i]) waitCnt[i] = 0;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_outputs", {gnt, gntId, busy, timeout}, 8'h00);
    applyStimulus(4'b1111, 4'b0000);
    applyStimulus(4'b1111, 4'b0000);
    checkOutput("rst_held_gnt", {4'b0, gnt}, 8'h00);
    rst_n = 1'b1;

    $display("[TB] round-robin rotation with all requesters");
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << (i % 4);
      applyStimulus(4'b1111, 4'b0000);
      checkOutput("rot_gnt_c1", {4'b0, gnt}, {4'b0, exp});
      applyStimulus(4'b1111, 4'b0000);
      checkOutput("rot_gnt_c2", {4'b0, gnt}, {4'b0, exp});
      applyStimulus(4'b1111, exp);
      checkOutput("rot_gap", {4'b0, gnt, 3'b0, busy}, 8'h00);
    end
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("rot_idle", {4'b0, gnt, 3'b0, busy}, 8'h00);

    $display("[TB] lone requester hold timeout");
    for (int k = 0; k < MH; k++) begin
      applyStimulus(4'b0100, 4'b0000);
      checkOutput("to_hold", {3'b0, timeout, gnt}, 8'h04);
    end
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("to_pulse", {3'b0, timeout, gnt}, 8'h10);
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("to_regrant", {3'b0, timeout, gnt}, 8'h04);

    $display("[TB] request drop at hold expiry");
    for (int k = 0; k < MH - 1; k++) begin
      applyStimulus(4'b0100, 4'b0000);
    end
    checkOutput("drop_last_hold", {4'b0, gnt}, 8'h04);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("drop_no_to", {3'b0, timeout, gnt}, 8'h00);
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] non-owner done ignored");
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("own1_gnt", {4'b0, gnt}, 8'h02);
    applyStimulus(4'b0011, 4'b0001);
    checkOutput("nonowner_done", {4'b0, gnt}, 8'h02);
    applyStimulus(4'b0011, 4'b0000);
    checkOutput("still_owner", {2'b0, gntId, gnt}, 8'h12);
    applyStimulus(4'b0011, 4'b0010);
    checkOutput("owner_done_gap", {3'b0, busy, gnt}, 8'h00);
    applyStimulus(4'b0011, 4'b0000);
    checkOutput("next_is_0", {2'b0, gntId, gnt}, 8'h01);
    applyStimulus(4'b0000, 4'b0001);
    applyStimulus(4'b0000, 4'b0000);

    $display("[TB] asynchronous reset mid-grant");
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("own3_gnt", {4'b0, gnt}, 8'h08);
    #2 rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_drop", {gnt, gntId, busy, timeout}, 8'h00);
    #1 rst_n = 1'b1;
    applyStimulus(4'b1001, 4'b0000);
    checkOutput("post_rst_first", {4'b0, gnt}, 8'h01);

    $display("[TB] random traffic");
    r = 4'b1001;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 15) == 0) r[b] = ~r[b];
      end
      applyStimulus(r, 4'($urandom & $urandom & $urandom));
      checkOutput("onehot", {7'b0, $onehot0(gnt)}, 8'h01);
      checkOutput("busy_or", {7'b0, busy}, {7'b0, |gnt});
      for (int i = 0; i < 4; i++) begin
        if (reqDrv[i] && !gnt[i]) waitCnt[i]++;
        else waitCnt[i] = 0;
      end
      checkOutput("starve", {7'b0, (waitCnt[0] > Bound) || (waitCnt[1] > Bound) ||
                                   (waitCnt[2] > Bound) || (waitCnt[3] > Bound)}, 8'h00);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
